// File: rtl/seq_subtractor32.sv
// Multi-cycle subtractor D = A - B - Bin, CHUNK bits per clock with the borrow rippling between chunks.
// Optional Z/V flag logic is enabled by defining SUB_FLAGS_EN; otherwise Z and V are tied low.
module seq_subtractor32 #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Z,
    output logic             V
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("seq_subtractor32: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   w_d_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_borrow;
    logic               r_bout;
    logic [CHUNK:0]     w_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign out_valid = (r_state == S_DONE);
    assign w_last    = (r_cnt == CNT_W'(N - 1));

    // One chunk per clock; the extra top bit of the difference is the borrow out of the chunk.
    always_comb begin
        w_diff  = {1'b0, r_a[r_cnt*CHUNK +: CHUNK]} - {1'b0, r_b[r_cnt*CHUNK +: CHUNK]}
                - {{CHUNK{1'b0}}, r_borrow};
        w_d_nxt = r_d;
        w_d_nxt[r_cnt*CHUNK +: CHUNK] = w_diff[CHUNK-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_d      <= w_d_nxt;
            r_borrow <= w_diff[CHUNK];
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_bout <= w_diff[CHUNK];
            end
        end
    end

    assign D    = r_d;
    assign Bout = r_bout;

`ifdef SUB_FLAGS_EN
    logic             r_bp_msb;
    logic             r_z;
    logic             r_v;
    logic [WIDTH-1:0] w_bp;

    // Overflow is judged against B+Bin, so keep only the sign bit of that sum from the accept edge.
    assign w_bp = B + {{(WIDTH-1){1'b0}}, Bin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bp_msb <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
        end else if (w_accept) begin
            r_bp_msb <= w_bp[WIDTH-1];
        end else if ((r_state == S_RUN) && w_last) begin
            r_z <= (w_d_nxt == '0);
            r_v <= (r_a[WIDTH-1] != r_bp_msb) & (w_d_nxt[WIDTH-1] != r_a[WIDTH-1]);
        end
    end

    assign Z = r_z;
    assign V = r_v;
`else
    assign Z = 1'b0;
    assign V = 1'b0;
`endif

endmodule
